pipe_hazard_ctrl: RTL and testbench

//  Sequencing controller for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM).

---
 rtl/pipe_hazard_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl_lu_hazard_cmp.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MD_WAIT    = 2'd1,
        REDIR_PEND = 2'd2
    } state_e;

    // x0 is hard-wired to zero, so it never creates a load-use dependency.
    localparam int unsigned REG_ZERO = 0;

    // Canonical bubble (addi x0, x0, 0).
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle.
// master: datapath side (drives hazard inputs); slave: controller side.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned AW = 14,
    parameter int unsigned RW = 5
);
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [RW-1:0] ex_rd;
    logic          ex_mem_read;
    logic          ex_md_valid;
    logic          ex_br_taken;
    logic [AW-1:0] ex_br_target;
    logic          imem_ready;

    logic          pc_en;
    logic          pc_sel_redir;
    logic [AW-1:0] redirect_pc;
    logic          ifid_en;
    logic          idex_en;
    logic          ifid_flush;
    logic          idex_flush;
    logic          exmem_flush;
    logic          md_done;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_md_valid, ex_br_taken, ex_br_target, imem_ready,
        input  pc_en, pc_sel_redir, redirect_pc, ifid_en, idex_en,
               ifid_flush, idex_flush, exmem_flush, md_done
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_md_valid, ex_br_taken, ex_br_target, imem_ready,
        output pc_en, pc_sel_redir, redirect_pc, ifid_en, idex_en,
               ifid_flush, idex_flush, exmem_flush, md_done
    );
endinterface

// File: rtl/pipe_hazard_ctrl_lu_hazard_cmp.sv
// Combinational load-use comparator: a load in EX whose destination is read by the
// instruction in ID.
module lu_hazard_cmp
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned RW = 5
) (
    input  logic [RW-1:0] rs1,
    input  logic [RW-1:0] rs2,
    input  logic          use_rs1,
    input  logic          use_rs2,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_mem_read,
    output logic          hit
);

    // Match only on sources the ID instruction really reads; x0 never hazards.
    always_comb begin
        hit = ex_mem_read && (ex_rd != RW'(REG_ZERO)) &&
              ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: per-stage enable/flush strobes for load-use stalls,
// multi-cycle MUL/DIV occupancy and taken-branch redirects.
// Optional build macro PIPE_HAZARD_STATS_EN adds saturating stall/redirect counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned AW     = 14,
    parameter int unsigned RW     = 5,
    parameter int unsigned MD_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef PIPE_HAZARD_STATS_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [3:0] MdInit = 4'(MD_LAT - 1);

    state_e        state_q, state_d;
    logic [3:0]    md_cnt_q, md_cnt_d;
    logic [AW-1:0] redir_q, redir_d;
    logic          lu_hit;

    logic          pc_en, pc_sel_redir, ifid_en, idex_en;
    logic          ifid_flush, idex_flush, exmem_flush, md_done;
    logic [AW-1:0] redirect_pc;

    lu_hazard_cmp #(.RW(RW)) u_lu_cmp (
        .rs1         (bus.id_rs1),
        .rs2         (bus.id_rs2),
        .use_rs1     (bus.id_use_rs1),
        .use_rs2     (bus.id_use_rs2),
        .ex_rd       (bus.ex_rd),
        .ex_mem_read (bus.ex_mem_read),
        .hit         (lu_hit)
    );

    // Mealy decode of state + inputs into strobes and next-state values.
    always_comb begin
        pc_en        = 1'b1;
        pc_sel_redir = 1'b0;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        md_done      = 1'b0;
        redirect_pc  = redir_q;
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        redir_d      = redir_q;

        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            redirect_pc = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.ex_br_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        if (bus.imem_ready) begin
                            pc_sel_redir = 1'b1;
                            redirect_pc  = bus.ex_br_target;
                        end else begin
                            // Hold the target until IMEM can accept the fetch.
                            pc_en   = 1'b0;
                            redir_d = bus.ex_br_target;
                            state_d = REDIR_PEND;
                        end
                    end else if (bus.ex_md_valid) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                        md_cnt_d    = MdInit;
                        state_d     = MD_WAIT;
                    end else if (lu_hit) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end else if (!bus.imem_ready) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (md_cnt_q == 4'd1) begin
                        // Result valid: release the pipe; still respect a slow IMEM.
                        md_done    = 1'b1;
                        pc_en      = bus.imem_ready;
                        ifid_flush = !bus.imem_ready;
                        md_cnt_d   = '0;
                        state_d    = RUN;
                    end else begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                        md_cnt_d    = md_cnt_q - 4'd1;
                    end
                end
                REDIR_PEND: begin
                    // EX holds a bubble here, so ex_br_taken is not looked at.
                    ifid_flush = 1'b1;
                    if (bus.imem_ready) begin
                        pc_sel_redir = 1'b1;
                        state_d      = RUN;
                    end else begin
                        pc_en = 1'b0;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // FSM state, MUL/DIV countdown and latched redirect target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
            redir_q  <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            redir_q  <= redir_d;
        end
    end

`ifdef PIPE_HAZARD_STATS_EN
    // Saturating counters of fetch-stall cycles and taken redirects.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
            if (pc_sel_redir && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

    assign bus.pc_en        = pc_en;
    assign bus.pc_sel_redir = pc_sel_redir;
    assign bus.redirect_pc  = redirect_pc;
    assign bus.ifid_en      = ifid_en;
    assign bus.idex_en      = idex_en;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_flush   = idex_flush;
    assign bus.exmem_flush  = exmem_flush;
    assign bus.md_done      = md_done;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MD_LAT = 4).
// Strobe vector order: {pc_en, pc_sel_redir, ifid_en, idex_en,
//                       ifid_flush, idex_flush, exmem_flush, md_done}
module tb_pipe_hazard_ctrl;

    localparam int unsigned AW = 14;
    localparam int unsigned RW = 5;

    localparam logic [7:0] C_RESET  = 8'b0000_1110;
    localparam logic [7:0] C_IDLE   = 8'b1011_0000;
    localparam logic [7:0] C_LU     = 8'b0001_0100;
    localparam logic [7:0] C_MD     = 8'b0000_0010;
    localparam logic [7:0] C_MDDONE = 8'b1011_0001;
    localparam logic [7:0] C_BR_RDY = 8'b1111_1100;
    localparam logic [7:0] C_BR_NR  = 8'b0011_1100;
    localparam logic [7:0] C_PEND   = 8'b0011_1000;
    localparam logic [7:0] C_PEND_R = 8'b1111_1000;
    localparam logic [7:0] C_IWAIT  = 8'b0011_1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    pipe_hazard_ctrl_if #(.AW(AW), .RW(RW)) bus ();

`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipe_hazard_ctrl #(.AW(AW), .RW(RW), .MD_LAT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef PIPE_HAZARD_STATS_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ctl;
    assign ctl = {bus.pc_en, bus.pc_sel_redir, bus.ifid_en, bus.idex_en,
                  bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.md_done};

    // Next cycle: inputs change just after the rising edge, back to a quiet pipe.
    task automatic next_idle();
        @(posedge clk);
        #1;
        bus.id_rs1       = '0;
        bus.id_rs2       = '0;
        bus.id_use_rs1   = 1'b0;
        bus.id_use_rs2   = 1'b0;
        bus.ex_rd        = '0;
        bus.ex_mem_read  = 1'b0;
        bus.ex_md_valid  = 1'b0;
        bus.ex_br_taken  = 1'b0;
        bus.ex_br_target = '0;
        bus.imem_ready   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        next_idle();
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ctl !== C_RESET) begin
            $display("FAIL reset_strobes: got %b, want %b", ctl, C_RESET);
            n_fail++;
        end
        n_checks++;
        if (bus.redirect_pc !== 14'h0) begin
            $display("FAIL reset_redirect_pc: got %h, want 0", bus.redirect_pc);
            n_fail++;
        end
        next_idle();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl !== C_IDLE) begin
            $display("FAIL reset_release_idle: got %b, want %b", ctl, C_IDLE);
            n_fail++;
        end
`ifdef PIPE_HAZARD_STATS_EN
        n_checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            $display("FAIL reset_counters: got %0d/%0d, want 0/0", stall_cnt, flush_cnt);
            n_fail++;
        end
`endif
    endtask

    task automatic test_load_use();
        // {mem_read, ex_rd, rs1, use1, rs2, use2, imem_ready} -> expected strobes
        logic [7:0]  exp [7];
        logic [20:0] vec [7];
        vec[0] = {1'b1, 5'd5, 5'd5, 1'b1, 5'd1, 1'b1, 1'b1}; exp[0] = C_LU;
        vec[1] = {1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1}; exp[1] = C_IDLE;
        vec[2] = {1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1}; exp[2] = C_IDLE;
        vec[3] = {1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1}; exp[3] = C_LU;
        vec[4] = {1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b1}; exp[4] = C_IDLE;
        vec[5] = {1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1}; exp[5] = C_IDLE;
        vec[6] = {1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0}; exp[6] = C_IWAIT;
        for (int i = 0; i < 7; i++) begin
            next_idle();
            {bus.ex_mem_read, bus.ex_rd, bus.id_rs1, bus.id_use_rs1,
             bus.id_rs2, bus.id_use_rs2, bus.imem_ready} = vec[i];
            @(negedge clk);
            n_checks++;
            if (ctl !== exp[i]) begin
                $display("FAIL load_use[%0d]: got %b, want %b", i, ctl, exp[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_mul_div();
        logic [7:0] exp [5];
        exp[0] = C_MD; exp[1] = C_MD; exp[2] = C_MD; exp[3] = C_MDDONE; exp[4] = C_IDLE;
        for (int i = 0; i < 5; i++) begin
            next_idle();
            bus.ex_md_valid = (i == 0);
            @(negedge clk);
            n_checks++;
            if (ctl !== exp[i]) begin
                $display("FAIL mul_div[%0d]: got %b, want %b", i, ctl, exp[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_branch_ready();
        next_idle();
        bus.ex_br_taken  = 1'b1;
        bus.ex_br_target = 14'h0123;
        @(negedge clk);
        n_checks++;
        if (ctl !== C_BR_RDY || bus.redirect_pc !== 14'h0123) begin
            $display("FAIL branch_ready: got %b/%h, want %b/0123", ctl, bus.redirect_pc,
                     C_BR_RDY);
            n_fail++;
        end
        next_idle();
        @(negedge clk);
        n_checks++;
        if (ctl !== C_IDLE) begin
            $display("FAIL branch_ready_after: got %b, want %b", ctl, C_IDLE);
            n_fail++;
        end
    endtask

    task automatic test_branch_pending();
        next_idle();
        bus.ex_br_taken  = 1'b1;
        bus.ex_br_target = 14'h3FFF;
        bus.imem_ready   = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl !== C_BR_NR) begin
            $display("FAIL branch_not_ready: got %b, want %b", ctl, C_BR_NR);
            n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            next_idle();
            bus.imem_ready = 1'b0;
            // A branch seen while pending must not disturb the latched target.
            bus.ex_br_taken  = (i == 1);
            bus.ex_br_target = 14'h0055;
            @(negedge clk);
            n_checks++;
            if (ctl !== C_PEND || bus.redirect_pc !== 14'h3FFF) begin
                $display("FAIL redir_pend[%0d]: got %b/%h, want %b/3fff", i, ctl,
                         bus.redirect_pc, C_PEND);
                n_fail++;
            end
        end
        next_idle();
        @(negedge clk);
        n_checks++;
        if (ctl !== C_PEND_R || bus.redirect_pc !== 14'h3FFF) begin
            $display("FAIL redir_release: got %b/%h, want %b/3fff", ctl, bus.redirect_pc,
                     C_PEND_R);
            n_fail++;
        end
        next_idle();
        @(negedge clk);
        n_checks++;
        if (ctl !== C_IDLE) begin
            $display("FAIL redir_after: got %b, want %b", ctl, C_IDLE);
            n_fail++;
        end
    endtask

    task automatic test_branch_lu();
        next_idle();
        bus.ex_br_taken  = 1'b1;
        bus.ex_br_target = 14'h0200;
        bus.ex_mem_read  = 1'b1;
        bus.ex_rd        = 5'd5;
        bus.id_rs1       = 5'd5;
        bus.id_use_rs1   = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl !== C_BR_RDY || bus.redirect_pc !== 14'h0200) begin
            $display("FAIL branch_over_lu: got %b/%h, want %b/0200", ctl, bus.redirect_pc,
                     C_BR_RDY);
            n_fail++;
        end
        next_idle();
        @(negedge clk);
        n_checks++;
        if (ctl !== C_IDLE) begin
            $display("FAIL branch_over_lu_after: got %b, want %b", ctl, C_IDLE);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_op();
        // MUL/DIV: issue cycle, first wait cycle, then reset while md_cnt == 2.
        next_idle();
        bus.ex_md_valid = 1'b1;
        next_idle();
        next_idle();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl !== C_RESET) begin
            $display("FAIL reset_md_strobes: got %b, want %b", ctl, C_RESET);
            n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            next_idle();
            rst_n = 1'b1;
            @(negedge clk);
            n_checks++;
            if (ctl !== C_IDLE) begin
                $display("FAIL reset_md_after[%0d]: got %b, want %b", i, ctl, C_IDLE);
                n_fail++;
            end
        end
`ifdef PIPE_HAZARD_STATS_EN
        n_checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            $display("FAIL reset_md_counters: got %0d/%0d, want 0/0", stall_cnt, flush_cnt);
            n_fail++;
        end
`endif
        // Pending redirect aborted by reset: target must be forgotten.
        next_idle();
        bus.ex_br_taken  = 1'b1;
        bus.ex_br_target = 14'h2AAA;
        bus.imem_ready   = 1'b0;
        next_idle();
        rst_n = 1'b0;
        next_idle();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl !== C_IDLE || bus.redirect_pc !== 14'h0) begin
            $display("FAIL reset_redir_abort: got %b/%h, want %b/0000", ctl, bus.redirect_pc,
                     C_IDLE);
            n_fail++;
        end
    endtask

`ifdef PIPE_HAZARD_STATS_EN
    task automatic test_stats();
        // One load-use stall then one taken redirect after a clean reset.
        next_idle();
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = 5'd9;
        bus.id_rs2      = 5'd9;
        bus.id_use_rs2  = 1'b1;
        next_idle();
        bus.ex_br_taken  = 1'b1;
        bus.ex_br_target = 14'h0040;
        next_idle();
        @(negedge clk);
        n_checks++;
        if (stall_cnt !== 32'd1 || flush_cnt !== 32'd1) begin
            $display("FAIL stats_counts: got %0d/%0d, want 1/1", stall_cnt, flush_cnt);
            n_fail++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_mul_div();
        test_branch_ready();
        test_branch_pending();
        test_branch_lu();
        test_reset_mid_op();
`ifdef PIPE_HAZARD_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
